// File: rtl/m10k_share_pkg.sv
// Shared types for the M10K sequencer/arbiter: FSM states, width defaults
// and the read-response tag carried alongside the memory read latency.
package m10k_share_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic id;
    logic oob;
  } tag_t;

endpackage

// File: rtl/m10k_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; combinational grant, last-grant pointer
// advances only when a grant is issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant
);

  // 1 = requester 1 was granted most recently; resets to 1 so r0 wins first conflict
  logic last_q;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else if (|grant) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/m10k_share_ctrl.sv
// Fills the first DEPTH words of one M10K with INIT_VALUE, then shares it
// between two requesters with round-robin grants and per-port read returns.
module m10k_share_ctrl
  import m10k_share_pkg::*;
#(
  parameter int                DATA_W     = DATA_W_DEF,
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                DEPTH      = 16,
  parameter logic [DATA_W-1:0] INIT_VALUE = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reinit,
  output logic              start,
  input  logic              r0_valid,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ready,
  output logic              r0_rsp_valid,
  output logic [DATA_W-1:0] r0_rsp_data,
  input  logic              r1_valid,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ready,
  output logic              r1_rsp_valid,
  output logic [DATA_W-1:0] r1_rsp_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_INIT: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (reinit) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign start = (state_q == ST_RUN);

  logic       run_en;
  logic [1:0] grant;

  assign run_en = (state_q == ST_RUN) && !reinit;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .valid ({r1_valid, r0_valid}),
    .en    (run_en),
    .grant (grant)
  );

  assign r0_ready = grant[0];
  assign r1_ready = grant[1];

  logic              accept, sel, req_we, req_oob;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  assign accept    = |grant;
  assign sel       = grant[1];
  assign req_we    = sel ? r1_we    : r0_we;
  assign req_addr  = sel ? r1_addr  : r0_addr;
  assign req_wdata = sel ? r1_wdata : r0_wdata;
  // Out-of-range requests are still accepted; they just never touch the array
  assign req_oob   = ({1'b0, req_addr} >= DEPTH_X);

  // Tag rides alongside the memory's registered read so the response
  // can be steered to the right port and zeroed if out of range.
  tag_t              tag0_d, tag0_q, tag1_q;
  logic [DATA_W-1:0] rsp_dat;

  always_comb begin
    tag0_d       = '0;
    tag0_d.valid = accept && !req_we;
    tag0_d.id    = sel;
    tag0_d.oob   = req_oob;
  end

  assign rsp_dat = tag1_q.oob ? '0 : mem_rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_raddr    <= '0;
      mem_wdata    <= '0;
      tag0_q       <= '0;
      tag1_q       <= '0;
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
      r0_rsp_data  <= '0;
      r1_rsp_data  <= '0;
    end else begin
      mem_we       <= 1'b0;
      tag0_q       <= tag0_d;
      tag1_q       <= tag0_q;
      r0_rsp_valid <= tag1_q.valid && !tag1_q.id;
      r1_rsp_valid <= tag1_q.valid && tag1_q.id;
      if (tag1_q.valid && !tag1_q.id) r0_rsp_data <= rsp_dat;
      if (tag1_q.valid && tag1_q.id)  r1_rsp_data <= rsp_dat;

      if (state_q == ST_INIT) begin
        mem_we    <= 1'b1;
        mem_waddr <= idx_q;
        mem_wdata <= INIT_VALUE;
      end else if (accept) begin
        if (req_we) begin
          mem_we    <= !req_oob;
          mem_waddr <= req_addr;
          mem_wdata <= req_wdata;
        end else begin
          mem_raddr <= req_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_m10k_share_ctrl.sv
// Randomised and directed bench for m10k_share_ctrl with a behavioural M10K,
// a spec-level reference model and a decoupled response scoreboard.
module tb_m10k_share_ctrl;

  localparam int DEPTH = 16;
  localparam logic [7:0] INITV = 8'd1;

  logic       clk, reset, reinit, start;
  logic       r0_valid, r0_we, r0_ready, r0_rsp_valid;
  logic [7:0] r0_addr, r0_wdata, r0_rsp_data;
  logic       r1_valid, r1_we, r1_ready, r1_rsp_valid;
  logic [7:0] r1_addr, r1_wdata, r1_rsp_data;
  logic       mem_we;
  logic [7:0] mem_waddr, mem_raddr, mem_wdata, mem_rdata;

  m10k_share_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .INIT_VALUE(INITV)) dut (
    .clk(clk), .reset(reset), .reinit(reinit), .start(start),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_data(r0_rsp_data),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_data(r1_rsp_data),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural M10K: registered read, write visible to reads one edge later
  logic [7:0] m10k [256];
  initial begin
    for (int i = 0; i < 256; i++) m10k[i] = 8'h00;
    mem_rdata = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_we) m10k[mem_waddr] <= mem_wdata;
    mem_rdata <= m10k[mem_raddr];
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { logic we; logic [7:0] addr; logic [7:0] wdata; } req_t;
  typedef struct { logic [7:0] data; int due; } exp_t;

  req_t dq0[$], dq1[$];
  exp_t q0[$], q1[$];
  logic jitter = 1'b0;

  // Reference model state
  logic       started = 1'b0;
  int         cyc = 0;
  logic       run = 1'b0;
  int         cnt = 0;
  int         last = 1;
  logic       exp_we = 1'b0;
  logic [7:0] exp_waddr = 8'h00, exp_wdata = 8'h00;
  logic [7:0] ref_mem [DEPTH];

  function automatic int grant_of(input logic v0, input logic v1, input int lst);
    if (v0 && v1) return (lst == 1) ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    logic       w;
    logic [7:0] a, d;
    cyc++;
    started = 1'b1;
    exp_we  = 1'b0;
    if (!reset) begin
      run = 1'b0; cnt = 0; last = 1;
      q0.delete(); q1.delete();
    end else if (!run) begin
      exp_we = 1'b1; exp_waddr = 8'(cnt); exp_wdata = INITV;
      ref_mem[cnt] = INITV;
      cnt++;
      if (cnt == DEPTH) run = 1'b1;
    end else if (reinit) begin
      run = 1'b0; cnt = 0;
    end else begin
      g = grant_of(r0_valid, r1_valid, last);
      if (g >= 0) begin
        last = g;
        w = (g == 0) ? r0_we    : r1_we;
        a = (g == 0) ? r0_addr  : r1_addr;
        d = (g == 0) ? r0_wdata : r1_wdata;
        if (w) begin
          if (int'(a) < DEPTH) begin
            exp_we = 1'b1; exp_waddr = a; exp_wdata = d;
            ref_mem[a] = d;
          end
        end else begin
          exp_t e;
          e.data = (int'(a) < DEPTH) ? ref_mem[a] : 8'h00;
          e.due  = cyc + 2;
          if (g == 0) q0.push_back(e); else q1.push_back(e);
        end
      end
    end
  end

  // Mid-cycle check of handshake and memory-side outputs against the model
  always @(negedge clk) begin
    if (started) begin
      int g;
      g = grant_of(r0_valid, r1_valid, last);
      chk("r0_ready", 32'(r0_ready), 32'(run && !reinit && g == 0));
      chk("r1_ready", 32'(r1_ready), 32'(run && !reinit && g == 1));
      chk("start", 32'(start), 32'(run));
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      if (exp_we) begin
        chk("mem_waddr", 32'(mem_waddr), 32'(exp_waddr));
        chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
      end
    end
  end

  task automatic mon(input int id, input logic v, input logic [7:0] d);
    exp_t e;
    int   n;
    n = (id == 0) ? q0.size() : q1.size();
    if (v) begin
      if (n == 0) begin
        chk($sformatf("rsp%0d_unexpected", id), 32'(v), 32'd0);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("rsp%0d_data", id), 32'(d), 32'(e.data));
        chk($sformatf("rsp%0d_latency", id), 32'(cyc), 32'(e.due));
      end
    end else if (n > 0) begin
      e = (id == 0) ? q0[0] : q1[0];
      if (e.due <= cyc) begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("rsp%0d_missing", id), 32'(v), 32'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      mon(0, r0_rsp_valid, r0_rsp_data);
      mon(1, r1_rsp_valid, r1_rsp_data);
    end
  end

  // Per-port drivers: hold the head request until it is accepted
  initial begin
    logic acc;
    req_t t;
    r0_valid = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    forever begin
      @(negedge clk);
      acc = r0_valid && r0_ready && reset;
      @(posedge clk); #1;
      if (acc) t = dq0.pop_front();
      if (dq0.size() > 0 && !(jitter && $urandom_range(0, 3) == 0)) begin
        r0_valid = 1; r0_we = dq0[0].we; r0_addr = dq0[0].addr; r0_wdata = dq0[0].wdata;
      end else r0_valid = 0;
    end
  end

  initial begin
    logic acc;
    req_t t;
    r1_valid = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
    forever begin
      @(negedge clk);
      acc = r1_valid && r1_ready && reset;
      @(posedge clk); #1;
      if (acc) t = dq1.pop_front();
      if (dq1.size() > 0 && !(jitter && $urandom_range(0, 3) == 0)) begin
        r1_valid = 1; r1_we = dq1[0].we; r1_addr = dq1[0].addr; r1_wdata = dq1[0].wdata;
      end else r1_valid = 0;
    end
  end

  task automatic push(input int port, input logic we, input logic [7:0] addr, input logic [7:0] wd);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wd;
    if (port == 0) dq0.push_back(r); else dq1.push_back(r);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (dq0.size() == 0 && dq1.size() == 0) break;
      @(posedge clk); #2;
    end
    chk("drain_timeout", 32'(dq0.size() + dq1.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start"}, 32'(start), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_waddr"}, 32'(mem_waddr), 32'd0);
    chk({tag, "_mem_raddr"}, 32'(mem_raddr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_r0_rsp_valid"}, 32'(r0_rsp_valid), 32'd0);
    chk({tag, "_r1_rsp_valid"}, 32'(r1_rsp_valid), 32'd0);
    chk({tag, "_r0_rsp_data"}, 32'(r0_rsp_data), 32'd0);
    chk({tag, "_r1_rsp_data"}, 32'(r1_rsp_data), 32'd0);
    chk({tag, "_r0_ready"}, 32'(r0_ready), 32'd0);
    chk({tag, "_r1_ready"}, 32'(r1_ready), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    reinit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");

    // Conflict on the first RUN cycle: r0 writes -5 to addr 3, r1 reads it back
    push(0, 1'b1, 8'd3, 8'hFB);
    push(1, 1'b0, 8'd3, 8'h00);
    @(posedge clk); #2;
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("init_we", 32'(mem_we), 32'd1);
      chk("init_addr", 32'(mem_waddr), 32'(i));
      chk("init_data", 32'(mem_wdata), 32'(INITV));
      chk("init_start", 32'(start), 32'(i == DEPTH - 1));
    end
    drain(50);
    idle(4);

    // Both ports streaming reads: grants must alternate
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b0, 8'(5 + i), 8'h00);
      push(1, 1'b0, 8'(8 + i), 8'h00);
    end
    drain(50);
    idle(4);

    // Out-of-range write then read
    push(0, 1'b1, 8'd20, 8'h5A);
    push(0, 1'b0, 8'd20, 8'h00);
    drain(50);
    idle(4);

    // reinit with a read in flight, then confirm the refill
    push(1, 1'b0, 8'd4, 8'h00);
    drain(50);
    reinit = 1'b1;
    idle(1);
    reinit = 1'b0;
    push(1, 1'b0, 8'd3, 8'h00);
    drain(100);
    idle(4);

    // Reset one cycle after a read is accepted: response must be dropped
    push(0, 1'b0, 8'd2, 8'h00);
    drain(50);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #2;
    reset = 1'b1;
    idle(DEPTH + 4);

    // Random mixed traffic
    jitter = 1'b1;
    for (int i = 0; i < 80; i++) begin
      push(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 19)), 8'($urandom));
      push(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 19)), 8'($urandom));
    end
    drain(2000);
    jitter = 1'b0;
    idle(6);

    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/m10k_share_ctrl.md
# m10k_share_ctrl

Sequencer and two-requester arbiter for one 1K×8 M10K block with a one-cycle registered read port. After reset, it fills the first DEPTH words with INIT_VALUE and raises `start`. It then shares the single memory between requester 0 (compute engine) and requester 1 (host/readback) using round-robin grants and per-requester read-response return. It sits between the compute datapath and the external M10K instance, replacing the ad-hoc init loop and direct address muxing.

## Interface
Parameters:
- DATA_W, 8, signed data width
- ADDR_W, 8, address width
- DEPTH, 16, words initialised and legal address range (0..DEPTH-1); DEPTH ≤ 2^ADDR_W
- INIT_VALUE, 8'sd1, fill value written during init

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset; sampled on the clk rising edge
- reinit  in  1  level; when high in RUN, restarts the init fill
- start  out  1  high while in RUN
- rN_valid  in  1  request valid (N = 0, 1)
- rN_we  in  1  1 = write, 0 = read
- rN_addr  in  ADDR_W  request address
- rN_wdata  in  DATA_W  write data
- rN_ready  out  1  request accepted this cycle when valid && ready (combinational)
- rN_rsp_valid  out  1  one-cycle pulse; read data valid
- rN_rsp_data  out  DATA_W  read data, qualified by rN_rsp_valid
- mem_we  out  1  registered write enable to M10K
- mem_waddr, mem_raddr  out  ADDR_W  registered addresses
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  M10K q; valid one edge after mem_raddr is presented

## Operation
- States: INIT and RUN. Reset places the block in INIT with idx = 0.
- INIT behaviour:
  - Each cycle, register mem_we = 1, mem_waddr = idx, mem_wdata = INIT_VALUE, then idx++.
  - On the write of idx = DEPTH-1, go to RUN and set start to 1 on the same edge.
  - rN_ready is 0 throughout INIT; reinit is ignored.
- RUN behaviour:
  - Grant at most one request per cycle.
  - Exactly one valid: that requester is granted.
  - Both valid: grant the requester that was not granted most recently; the last-grant pointer resets so that r0 wins the first conflict.
  - rN_ready = (state == RUN) && !reinit && grant_N.
- Accepted write: on the next edge, mem_we = 1 and mem_waddr/mem_wdata are driven.
- Accepted read: on the next edge, mem_raddr is driven and a 2-stage tag pipe {valid, id, oob} advances.
- Out-of-range address (addr ≥ DEPTH): the request is still accepted.
  - Write: mem_we is held at 0.
  - Read: the response returns data 0.
- reinit high in RUN:
  - On the next edge, go to INIT with idx = 0 and start = 0.
  - No grant is given in the cycle reinit is high.
  - Reads already in flight still deliver their responses.
- mem_we is 0 in any cycle with no accepted write and no INIT write.

## Timing
- Reset values:
  - start = 0, mem_we = 0, mem_waddr = mem_raddr = 0, mem_wdata = 0.
  - rsp_valid = 0, rsp_data = 0, tag pipe cleared, rr pointer = r1, ready = 0.
- Init duration: first edge with reset high is E1. INIT writes occupy edges E1..E_DEPTH; start = 1 after E_DEPTH. The first possible grant is the cycle after E_DEPTH.
- Read latency:
  - Accept at edge k, mem_raddr is driven after k.
  - M10K captures at k+1; rsp_valid and rsp_data are registered at k+2.
  - Result: 2 cycles from acceptance to response.
- Write commit: accept at k, mem_we is driven after k, memory updates at k+1.
- Ordering: a read accepted one cycle after a write to the same address returns the new data. Only one grant per cycle, so there is no same-cycle hazard.
- Throughput: one request per cycle, sustained.
- Reset asserted mid-operation: all outputs take reset values after the edge; in-flight responses are dropped.

## Structure
- Package m10k_share_pkg:
  - state enum {INIT, RUN}
  - DATA_W/ADDR_W defaults
  - response tag struct {valid, id, oob}
- Sub-module rr_arb2:
  - Inputs: valid[1:0], en.
  - Outputs: grant[1:0].
  - Holds a last-grant register that updates only on accept.
- The M10K itself stays outside; the bench instantiates a 1-cycle-read behavioural model.

## Test plan
- Release reset → mem_we high for 16 consecutive cycles, addr 0..15, data 1; start rises after the 16th edge; ready stays 0 throughout.
- Both requests from the first RUN cycle: r0 writes addr 3 = -5, r1 reads addr 3 → r0 is granted first and r1 the next cycle. r1_rsp_valid pulses 2 cycles after r1's acceptance with data 8'hFB.
- Both requesters hold valid reads for 6 cycles → grants alternate r0, r1, r0, r1, r0, r1. Each response returns on the matching port with data 1.
- r0 writes addr 20 then reads addr 20 → mem_we stays 0; the response is valid with data 0.
- With an r1 read accepted, raise reinit one cycle → r1's response is still delivered, start drops, 16 init writes follow, and a subsequent read of addr 3 returns 1.
- Assert reset one cycle after a read is accepted → rsp_valid never pulses; all outputs are at reset values after the edge.
